// File: rtl/alarme_ctrl.sv
// Sequential alarm controller: arm/disarm, exit and entry delays, timed siren.
// Ports: clk, rst_n (sync, active-low), arm, disarm, P/W/M sensors in; A, armed, pending, zona, state out.
module alarme_ctrl #(
  parameter int EXIT_CYC  = 8,
  parameter int ENTRY_CYC = 4,
  parameter int SIREN_CYC = 16,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       P,
  input  logic       W,
  input  logic       M,
  output logic       A,
  output logic       armed,
  output logic       pending,
  output logic [2:0] zona,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARO   = 3'd4
  } st_t;

  localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_CYC - 1);
  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_CYC - 1);
  localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    zona_d;
  logic          hit;
  logic          cnt_z;

  assign hit   = W | M;
  assign cnt_z = (cnt_q == '0);
  assign state = st_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    zona_d = zona;
    if (disarm) begin
      st_d   = DESARMADO;
      cnt_d  = '0;
      zona_d = '0;
    end else begin
      case (st_q)
        DESARMADO: begin
          cnt_d = '0;
          if (arm) begin
            st_d  = SAIDA;
            cnt_d = EXIT_LD;
          end
        end
        SAIDA: begin
          if (cnt_z) begin
            st_d  = ARMADO;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ARMADO: begin
          cnt_d = '0;
          if (hit) begin
            st_d  = DISPARO;
            cnt_d = SIREN_LD;
          end else if (P) begin
            st_d  = ENTRADA;
            cnt_d = ENTRY_LD;
          end
        end
        ENTRADA: begin
          if (hit || cnt_z) begin
            st_d  = DISPARO;
            cnt_d = SIREN_LD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DISPARO: begin
          // siren timeout re-arms; live sensors retrigger next edge
          if (cnt_z) begin
            st_d  = ARMADO;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          st_d   = DESARMADO;
          cnt_d  = '0;
          zona_d = '0;
        end
      endcase
      // sensors latch only while armed-family and not leaving to idle
      if ((st_q == ARMADO) || (st_q == ENTRADA) || (st_q == DISPARO))
        zona_d = zona | {P, W, M};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= DESARMADO;
      cnt_q   <= '0;
      zona    <= '0;
      A       <= 1'b0;
      armed   <= 1'b0;
      pending <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      zona    <= zona_d;
      A       <= (st_d == DISPARO);
      armed   <= (st_d == ARMADO) || (st_d == ENTRADA) ||
                 (st_d == DISPARO);
      pending <= (st_d == SAIDA) || (st_d == ENTRADA);
    end
  end

endmodule
